group_serializer: RTL and testbench

Parallel-to-serial converter that is the transmit-side counterpart of the group deserializer. It accepts one `GROUP_SIZE`-bit group on a load handshake and streams it out one bit per enabled cycle, MSB first. A downstream deserializer fed from `element` and enabled with `elementValid` rebuilds the original group bit-for-bit. It sits between group-producing logic and any 1-bit serial consumer, and supports back-to-back groups with no idle cycle.

---
 rtl/group_serializer.sv | 94 +++++++++
 tb/tb_group_serializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/group_serializer.sv
// group_serializer
//
// Parallel-to-serial converter. A GROUP_SIZE-bit group is captured on an edge
// with load_i && ready_o. It is then streamed out MSB first, one bit per edge
// with enable_i=1. A new group may be loaded in the last-bit cycle, so groups
// can run back to back without an idle cycle.
//
// Ports
//   clk_i                 clock, rising edge
//   rst_i                 asynchronous reset, active high
//   load_i                request to capture grouped_elements_i (only when ready_o)
//   grouped_elements_i    group to transmit
//   enable_i              downstream consumes the current bit on this edge
//   ready_o               block can accept a group this cycle (combinational on enable_i)
//   element_o             current serial bit, 0 when element_valid_o=0
//   element_valid_o       element_o carries a live bit
//   group_done_o          one-cycle pulse after the last bit of a group is consumed
module group_serializer #(
    parameter int unsigned GROUP_SIZE  = 16,
    parameter int unsigned COUNT_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [GROUP_SIZE-1:0] grouped_elements_i,
    input  logic                  enable_i,
    output logic                  ready_o,
    output logic                  element_o,
    output logic                  element_valid_o,
    output logic                  group_done_o
);

    localparam logic [COUNT_WIDTH-1:0] LastIdx = COUNT_WIDTH'(GROUP_SIZE - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [GROUP_SIZE-1:0]   shadow_q, shadow_d;
    logic [COUNT_WIDTH-1:0]  bit_idx_q, bit_idx_d;
    logic                    done_q, done_d;

    logic last_bit;
    logic accept;

    // The last bit is being consumed on the coming edge.
    assign last_bit = (state_q == StSend) && (bit_idx_q == LastIdx) && enable_i;
    assign accept   = load_i && ready_o;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        bit_idx_d = bit_idx_q;
        done_d    = last_bit;
        if (accept) begin
            // Covers both the idle load and the back-to-back load on the last bit.
            state_d   = StSend;
            shadow_d  = grouped_elements_i;
            bit_idx_d = '0;
        end else if (last_bit) begin
            // Final shift leaves the shadow cleared; counter parks at 0.
            state_d   = StIdle;
            shadow_d  = shadow_q << 1;
            bit_idx_d = '0;
        end else if ((state_q == StSend) && enable_i) begin
            shadow_d  = shadow_q << 1;
            bit_idx_d = bit_idx_q + COUNT_WIDTH'(1);
        end
    end

    // Outputs
    always_comb begin
        ready_o         = (state_q == StIdle) || last_bit;
        element_valid_o = (state_q == StSend);
        element_o       = (state_q == StSend) && shadow_q[GROUP_SIZE-1];
        group_done_o    = done_q;
    end

endmodule

// File: tb/tb_group_serializer.sv
// Self-checking bench for group_serializer: a queue-based model of the bit
// stream is compared against the DUT every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_group_serializer;

    localparam int GS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [GS-1:0] grp = '0;
    logic          en = 1'b0;
    logic          ready, element, element_valid, group_done;

    int total = 0;
    int bad   = 0;

    group_serializer #(.GROUP_SIZE(GS), .COUNT_WIDTH(5)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .load_i             (load),
        .grouped_elements_i (grp),
        .enable_i           (en),
        .ready_o            (ready),
        .element_o          (element),
        .element_valid_o    (element_valid),
        .group_done_o       (group_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining bits of the current group, MSB first.
    bit cur[$];
    bit done_m = 1'b0;
    int n_m;
    bit rdy_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur.delete();
            done_m = 1'b0;
        end else begin
            n_m    = cur.size();
            rdy_m  = (n_m == 0) || (n_m == 1 && en);
            done_m = (n_m == 1) && en;
            if (n_m > 0 && en) void'(cur.pop_front());
            if (load && rdy_m) begin
                cur.delete();
                for (int i = GS - 1; i >= 0; i--) cur.push_back(grp[i]);
            end
        end
    end

    // Per-cycle comparison against the model, plus bookkeeping of the stream.
    logic [31:0] rx = '0;
    int valid_cnt = 0;
    int done_cnt  = 0;

    always @(negedge clk) begin
        check("valid", {31'b0, element_valid}, {31'b0, cur.size() > 0});
        check("element", {31'b0, element}, {31'b0, (cur.size() > 0) ? cur[0] : 1'b0});
        check("ready", {31'b0, ready},
              {31'b0, (cur.size() == 0) || (cur.size() == 1 && en)});
        check("done", {31'b0, group_done}, {31'b0, done_m});
        if (element_valid) valid_cnt++;
        if (group_done) done_cnt++;
        if (element_valid && en) rx = {rx[30:0], element};
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        rx = '0;
        valid_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start(input logic [GS-1:0] g);
        load = 1'b1;
        grp  = g;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_valid", {31'b0, element_valid}, 32'd0);
        check("rst_elem", {31'b0, element}, 32'd0);
        check("rst_done", {31'b0, group_done}, 32'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // Single group
        en = 1'b1;
        clear_stats();
        start(16'hA5C3);
        step(18);
        check("single_data", rx, 32'h0000A5C3);
        check("single_valid_cnt", valid_cnt, 32'd16);
        check("single_done_cnt", done_cnt, 32'd1);
        check("single_ready", {31'b0, ready}, 32'd1);

        // Stall after the 4th transfer
        clear_stats();
        start(16'hF00F);
        step(4);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(14);
        check("stall_data", rx, 32'h0000F00F);
        check("stall_valid_cnt", valid_cnt, 32'd19);
        check("stall_done_cnt", done_cnt, 32'd1);

        // Back-to-back
        clear_stats();
        start(16'hFFFF);
        step(15);
        start(16'h0001);
        step(17);
        check("b2b_data", rx, 32'hFFFF0001);
        check("b2b_valid_cnt", valid_cnt, 32'd32);
        check("b2b_done_cnt", done_cnt, 32'd2);

        // Load while busy is ignored
        clear_stats();
        start(16'hAAAA);
        step(5);
        start(16'h1234);
        step(12);
        check("busy_data", rx, 32'h0000AAAA);
        check("busy_valid_cnt", valid_cnt, 32'd16);
        check("busy_done_cnt", done_cnt, 32'd1);

        // Loopback
        clear_stats();
        start(16'h8001);
        step(18);
        check("loop_data", rx, 32'h00008001);

        // Reset mid-stream at bitIndex 7
        start(16'hFFFF);
        step(7);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'b0, element_valid}, 32'd0);
        check("midrst_elem", {31'b0, element}, 32'd0);
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_done", {31'b0, group_done}, 32'd0);
        step(1);
        rst = 1'b0;
        clear_stats();
        step(5);
        check("postrst_valid_cnt", valid_cnt, 32'd0);
        check("postrst_done_cnt", done_cnt, 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            load = ($urandom_range(0, 3) == 0);
            grp  = GS'($urandom);
            en   = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst  = 1'b0;
        load = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
